// File: rtl/kfpga_config_pkg.sv
// kfpga_config_pkg: shared loader state encoding and default word width
package kfpga_config_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, SHIFT, DONE} state_t;
  localparam int DEFAULT_WORD_WIDTH = 16;
endpackage

// File: rtl/config_word_serializer.sv
// config_word_serializer: holds one bitstream word and shifts it out MSB-first
module config_word_serializer #(
  parameter int WORD_WIDTH = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  msb,
  output logic                  last
);
  logic [WORD_WIDTH-1:0] sreg;
  logic [CNT_WIDTH-1:0] cnt;
  // load a word with its usable bit count, then shift left one bit per cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sreg <= '0;
      cnt <= '0;
    end else if (load) begin
      sreg <= data;
      cnt <= count;
    end else if (shift && cnt != '0) begin
      sreg <= sreg << 1;
      cnt <= cnt - 1'b1;
    end
  assign msb = sreg[WORD_WIDTH-1];
  assign last = cnt == CNT_WIDTH'(1);
endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: clears the tile config chain, then shifts exactly CHAIN_LENGTH bits into it
module config_chain_loader
  import kfpga_config_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int CHAIN_LENGTH = 24
) (
  input  logic                  config_clock,
  input  logic                  config_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data_out,
  output logic                  chain_enable,
  output logic                  chain_nreset,
  input  logic                  chain_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  chain_error
);
  localparam int CNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
  state_t state, next;
  logic [CNT_WIDTH-1:0] bits_left, word_bits;
  logic msb, last;
  wire shifting = state == SHIFT;
  wire accept = state == FETCH && word_valid;
  assign word_bits = (int'(bits_left) < WORD_WIDTH) ? bits_left : CNT_WIDTH'(WORD_WIDTH);
  config_word_serializer #(.WORD_WIDTH(WORD_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ser (
    .clk(config_clock),
    .rst(config_reset),
    .load(accept),
    .shift(shifting),
    .data(word_data),
    .count(word_bits),
    .msb(msb),
    .last(last)
  );
  // state register
  always_ff @(posedge config_clock or posedge config_reset)
    if (config_reset) state <= IDLE;
    else state <= next;
  // sequencing: the last chain bit wins over word exhaustion so a final partial word ends the load
  always_comb begin
    next = state;
    next = state == IDLE  ? (start ? CLEAR : IDLE) :
           state == CLEAR ? FETCH :
           state == FETCH ? (word_valid ? SHIFT : FETCH) :
           state == SHIFT ? (bits_left == CNT_WIDTH'(1) ? DONE : last ? FETCH : SHIFT) :
           IDLE;
  end
  // bits still owed to the chain in this load
  always_ff @(posedge config_clock or posedge config_reset)
    if (config_reset) bits_left <= '0;
    else if (state == CLEAR) bits_left <= CNT_WIDTH'(CHAIN_LENGTH);
    else if (shifting && bits_left != '0) bits_left <= bits_left - 1'b1;
  // a cleared chain must read back zeros while loading; any 1 means a broken chain
  always_ff @(posedge config_clock or posedge config_reset)
    if (config_reset) chain_error <= 1'b0;
    else if (state == CLEAR) chain_error <= 1'b0;
    else if (shifting && chain_data_in) chain_error <= 1'b1;
  assign word_ready = state == FETCH;
  assign chain_enable = shifting;
  assign chain_data_out = shifting & msb;
  assign chain_nreset = ~(config_reset | state == CLEAR);
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: directed vectors against a modelled tile chain
module tb_config_chain_loader;
  logic clk = 0, config_reset = 1, start = 0, word_valid = 0, stuck = 0;
  logic [15:0] word_data = '0;
  logic word_ready, chain_data_out, chain_enable, chain_nreset, busy, done, chain_error;
  logic [23:0] chain;
  logic start2 = 0, valid2 = 0;
  logic [15:0] data2 = '0;
  logic ready2, dout2, en2, nrst2, busy2, done2, err2;
  logic [31:0] chain2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  config_chain_loader #(.WORD_WIDTH(16), .CHAIN_LENGTH(24)) dut (
    .config_clock(clk), .config_reset(config_reset), .start(start), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .chain_data_out(chain_data_out),
    .chain_enable(chain_enable), .chain_nreset(chain_nreset), .chain_data_in(stuck ? 1'b1 : chain[23]),
    .busy(busy), .done(done), .chain_error(chain_error));

  config_chain_loader #(.WORD_WIDTH(16), .CHAIN_LENGTH(32)) dut2 (
    .config_clock(clk), .config_reset(config_reset), .start(start2), .word_data(data2),
    .word_valid(valid2), .word_ready(ready2), .chain_data_out(dout2),
    .chain_enable(en2), .chain_nreset(nrst2), .chain_data_in(chain2[31]),
    .busy(busy2), .done(done2), .chain_error(err2));

  // tile chain models: cleared by config_nreset, shift toward config_out when enabled
  always @(posedge clk) begin
    if (!chain_nreset) chain <= '0;
    else if (chain_enable) chain <= {chain[22:0], chain_data_out};
    if (!nrst2) chain2 <= '0;
    else if (en2) chain2 <= {chain2[30:0], dout2};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] w0, w1;
    int vf;
    logic stuck, hold;
    logic [23:0] exp_chain;
    int exp_done;
    logic exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int cyc = 0, en = 0, nw = 0, done_cyc = -1, first_err = -1, dones = 0, extra_hs = 0;
    logic hs = 0, e2 = 1, edone = 0;
    stuck = v.stuck;
    if (v.hold) begin
      word_valid = 1;
      word_data = v.w0;
      repeat (3) begin
        @(negedge clk);
        if (word_ready || busy) extra_hs++;
      end
    end
    @(negedge clk);
    start = 1;
    word_data = v.w0;
    word_valid = 1;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = v.hold && cyc == 10;
      if (hs) nw++;
      word_data = nw == 0 ? v.w0 : nw == 1 ? v.w1 : 16'hFFFF;
      word_valid = v.hold || nw == 0 || (nw == 1 && cyc >= v.vf);
      hs = word_ready && word_valid;
      if (chain_enable) en++;
      if (cyc == 2) e2 = chain_error;
      if (cyc >= 2 && chain_error && first_err < 0) first_err = cyc;
      if (done) begin
        done_cyc = cyc;
        edone = chain_error;
      end
    end
    start = 0;
    repeat (4) begin
      @(negedge clk);
      if (hs) nw++;
      hs = word_ready && word_valid;
      if (done) dones++;
    end
    word_valid = 0;
    chk("chain_content", 64'(chain), 64'(v.exp_chain));
    chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    chk("enable_cycles", 64'(en), 64'd24);
    chk("err_at_done", 64'(edone), 64'(v.exp_err));
    chk("err_cleared", 64'(e2), 64'd0);
    chk("first_err_cycle", 64'(first_err), v.stuck ? 64'd4 : {64{1'b1}});
    chk("words_used", 64'(nw), 64'd2);
    chk("extra_done", 64'(dones), 64'd0);
    chk("idle_ready", 64'(extra_hs), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int en, cyc, nw, done_cyc;
    logic hs;
    vecs[0] = '{16'hA5C3, 16'h7E55, 0, 0, 0, 24'hA5C37E, 28, 0};
    vecs[1] = '{16'hA5C3, 16'h7E55, 29, 0, 0, 24'hA5C37E, 38, 0};
    vecs[2] = '{16'hFFFF, 16'hFF00, 0, 0, 0, 24'hFFFFFF, 28, 0};
    vecs[3] = '{16'h0001, 16'h8000, 0, 0, 0, 24'h000180, 28, 0};
    vecs[4] = '{16'h1234, 16'h5600, 0, 1, 0, 24'h123456, 28, 1};
    vecs[5] = '{16'h0000, 16'h00FF, 0, 0, 0, 24'h000000, 28, 0};
    vecs[6] = '{16'hA5C3, 16'h7E55, 0, 0, 1, 24'hA5C37E, 28, 0};
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(word_ready), 0);
    chk("rst_enable", 64'(chain_enable), 0);
    chk("rst_dout", 64'(chain_data_out), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(chain_error), 0);
    chk("rst_nreset", 64'(chain_nreset), 0);
    config_reset = 0;
    @(negedge clk);
    chk("idle_nreset", 64'(chain_nreset), 1);
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    // abort after 8 shifted bits
    @(negedge clk);
    start = 1;
    word_data = 16'hA5C3;
    word_valid = 1;
    en = 0;
    cyc = 0;
    while (en < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (chain_enable) en++;
    end
    @(negedge clk);
    config_reset = 1;
    #1;
    chk("abort_ready", 64'(word_ready), 0);
    chk("abort_enable", 64'(chain_enable), 0);
    chk("abort_dout", 64'(chain_data_out), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_nreset", 64'(chain_nreset), 0);
    @(negedge clk);
    chk("abort_chain_clear", 64'(chain), 0);
    chk("abort_no_done", 64'(done), 0);
    word_valid = 0;
    config_reset = 0;
    run_vec(vecs[0]);
    // 32-bit chain, exact word multiple
    @(negedge clk);
    start2 = 1;
    valid2 = 1;
    data2 = 16'h1234;
    cyc = 0;
    en = 0;
    nw = 0;
    hs = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start2 = 0;
      if (hs) nw++;
      data2 = nw == 0 ? 16'h1234 : 16'hABCD;
      valid2 = nw < 2;
      hs = ready2 && valid2;
      if (en2) en++;
      if (done2) done_cyc = cyc;
    end
    @(negedge clk);
    valid2 = 0;
    chk("c32_chain", 64'(chain2), 64'h1234ABCD);
    chk("c32_enable_cycles", 64'(en), 64'd32);
    chk("c32_done_cycle", 64'(done_cyc), 64'd36);
    chk("c32_words", 64'(nw), 64'd2);
    chk("c32_err", 64'(err2), 0);
    chk("c32_idle", 64'(busy2), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
